// File: rtl/sr_alu_sched_if.sv
// sr_alu_sched_if: request/response bundle between requesters and
// the shared-ALU scheduler.
interface sr_alu_sched_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_srcA;
  logic [N_REQ*32-1:0] req_srcB;
  logic [N_REQ*3-1:0]  req_oper;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_result;
  logic                rsp_zero;
  logic [ID_W-1:0]     rsp_id;

  modport master (
    output req_valid, req_srcA, req_srcB,
    output req_oper, rsp_ready,
    input  req_ready, rsp_valid, rsp_result,
    input  rsp_zero, rsp_id
  );

  modport slave (
    input  req_valid, req_srcA, req_srcB,
    input  req_oper, rsp_ready,
    output req_ready, rsp_valid, rsp_result,
    output rsp_zero, rsp_id
  );
endinterface

// File: rtl/sr_alu_sched.sv
// sr_alu_sched: shares one ALU among N_REQ requesters (round-robin).
// SR_ALU_SCHED_FIXED_PRIO_EN selects lowest-index fixed priority.
module sr_alu_sched #(
  parameter int N_REQ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sr_alu_sched_if.slave bus,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [2:0]      op_c;
  logic [ID_W-1:0] op_id;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld;

`ifndef SR_ALU_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  int              j;
`endif

  // Scan in reverse so the first hit in search order is kept last.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
`ifdef SR_ALU_SCHED_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_id  = ID_W'(i);
        gnt_vld = 1'b1;
      end
    end
`else
    j    = 0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = ID_W'(j);
      if (bus.req_valid[cand]) begin
        gnt_id  = cand;
        gnt_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_vld)
      bus.req_ready[gnt_id] = 1'b1;
  end

  assign alu_srcA = op_a;
  assign alu_srcB = op_b;
  assign alu_oper = op_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_a           <= '0;
      op_b           <= '0;
      op_c           <= '0;
      op_id          <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_id     <= '0;
`ifndef SR_ALU_SCHED_FIXED_PRIO_EN
      ptr            <= ID_W'(N_REQ - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            op_a  <= bus.req_srcA[int'(gnt_id)*32 +: 32];
            op_b  <= bus.req_srcB[int'(gnt_id)*32 +: 32];
            op_c  <= bus.req_oper[int'(gnt_id)*3 +: 3];
            op_id <= gnt_id;
`ifndef SR_ALU_SCHED_FIXED_PRIO_EN
            ptr   <= gnt_id;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= alu_result;
          bus.rsp_zero   <= alu_zero;
          bus.rsp_id     <= op_id;
          bus.rsp_valid  <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_alu_sched.sv
// tb_sr_alu_sched: directed checks of the shared-ALU scheduler
// with N_REQ=2 and N_REQ=4 instances driving a reference ALU.
module tb_sr_alu_sched;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sr_alu_sched_if #(.N_REQ(2)) b2 ();
  sr_alu_sched_if #(.N_REQ(4)) b4 ();

  logic [31:0] a2_a, a2_b, a2_r;
  logic [2:0]  a2_o;
  logic        a2_z;
  logic [31:0] a4_a, a4_b, a4_r;
  logic [2:0]  a4_o;
  logic        a4_z;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op
  );
    case (op)
      ALU_OR:   return a | b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SLTU: return {31'b0, a < b};
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      default:  return a + b;
    endcase
  endfunction

  always_comb begin
    a2_r = alu_f(a2_a, a2_b, a2_o);
    a2_z = (a2_r == 32'b0);
    a4_r = alu_f(a4_a, a4_b, a4_o);
    a4_z = (a4_r == 32'b0);
  end

  sr_alu_sched #(.N_REQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2),
    .alu_srcA(a2_a), .alu_srcB(a2_b), .alu_oper(a2_o),
    .alu_result(a2_r), .alu_zero(a2_z)
  );

  sr_alu_sched #(.N_REQ(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4),
    .alu_srcA(a4_a), .alu_srcB(a4_b), .alu_oper(a4_o),
    .alu_result(a4_r), .alu_zero(a4_z)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set2(
    input int          id,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op
  );
    b2.req_srcA[id*32 +: 32] = a;
    b2.req_srcB[id*32 +: 32] = b;
    b2.req_oper[id*3 +: 3]   = op;
    b2.req_valid[id]         = 1'b1;
  endtask

  task automatic set4(
    input int          id,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op
  );
    b4.req_srcA[id*32 +: 32] = a;
    b4.req_srcB[id*32 +: 32] = b;
    b4.req_oper[id*3 +: 3]   = op;
    b4.req_valid[id]         = 1'b1;
  endtask

  // Entered just after a rising edge with the request driven.
  task automatic xact2(
    input int          id,
    input bit          keep,
    input int          hold,
    input logic [31:0] res,
    input logic        zero
  );
    @(negedge clk);
    check("ready2", 32'(b2.req_ready), 32'(1 << id));
    @(posedge clk); #1;
    if (!keep) b2.req_valid[id] = 1'b0;
    @(negedge clk);
    check("exec_valid2", 32'(b2.rsp_valid), 32'd0);
    check("exec_rdy2", 32'(b2.req_ready), 32'd0);
    @(negedge clk);
    check("rsp_valid2", 32'(b2.rsp_valid), 32'd1);
    check("rsp_res2", b2.rsp_result, res);
    check("rsp_zero2", 32'(b2.rsp_zero), 32'(zero));
    check("rsp_id2", 32'(b2.rsp_id), 32'(id));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", 32'(b2.rsp_valid), 32'd1);
      check("bp_res", b2.rsp_result, res);
      check("bp_zero", 32'(b2.rsp_zero), 32'(zero));
      check("bp_id", 32'(b2.rsp_id), 32'(id));
      check("bp_rdy", 32'(b2.req_ready), 32'd0);
    end
    b2.rsp_ready = 1'b1;
    #1;
    check("pop_rdy2", 32'(b2.req_ready), 32'd0);
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  task automatic xact4(
    input int          id,
    input logic [31:0] res,
    input logic [2:0]  op
  );
    @(negedge clk);
    check("ready4", 32'(b4.req_ready), 32'(1 << id));
    @(posedge clk); #1;
    b4.req_valid[id] = 1'b0;
    @(negedge clk);
    check("oper4", 32'(a4_o), 32'(op));
    @(negedge clk);
    check("rsp_valid4", 32'(b4.rsp_valid), 32'd1);
    check("rsp_res4", b4.rsp_result, res);
    check("rsp_id4", 32'(b4.rsp_id), 32'(id));
    b4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b4.rsp_ready = 1'b0;
  endtask

  int          exp_id;
  logic        seen;
  logic [31:0] exp_r;

  initial begin
    b2.req_valid = '0;
    b2.req_srcA  = '0;
    b2.req_srcB  = '0;
    b2.req_oper  = '0;
    b2.rsp_ready = 1'b0;
    b4.req_valid = '0;
    b4.req_srcA  = '0;
    b4.req_srcB  = '0;
    b4.req_oper  = '0;
    b4.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(b2.req_ready), 32'd0);
    check("rst_valid", 32'(b2.rsp_valid), 32'd0);
    check("rst_res", b2.rsp_result, 32'd0);
    check("rst_zero", 32'(b2.rsp_zero), 32'd0);
    check("rst_id", 32'(b2.rsp_id), 32'd0);
    check("rst_srcA", a2_a, 32'd0);
    check("rst_oper", 32'(a2_o), 32'd0);
    check("rst_valid4", 32'(b4.rsp_valid), 32'd0);

    @(posedge clk); #1;
    set2(0, 32'd5, 32'd7, ALU_ADD);
    xact2(0, 1'b0, 0, 32'd12, 1'b0);

    set2(1, 32'd9, 32'd9, ALU_SUB);
    set2(0, 32'd1, 32'd2, ALU_ADD);
    b2.req_valid[0] = 1'b0;
    xact2(1, 1'b0, 0, 32'd0, 1'b1);

    // Backpressure with requester 0 waiting throughout.
    set2(1, 32'd9, 32'd9, ALU_SUB);
    @(negedge clk);
    check("bp_grant", 32'(b2.req_ready), 32'd2);
    @(posedge clk); #1;
    b2.req_valid[1] = 1'b0;
    set2(0, 32'd1, 32'd2, ALU_ADD);
    @(negedge clk);
    check("bp_exec_rdy", 32'(b2.req_ready), 32'd0);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_valid", 32'(b2.rsp_valid), 32'd1);
      check("bp_res", b2.rsp_result, 32'd0);
      check("bp_zero", 32'(b2.rsp_zero), 32'd1);
      check("bp_id", 32'(b2.rsp_id), 32'd1);
      check("bp_rdy", 32'(b2.req_ready), 32'd0);
    end
    b2.rsp_ready = 1'b1;
    #1;
    check("bp_pop_rdy", 32'(b2.req_ready), 32'd0);
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_after_rdy", 32'(b2.req_ready), 32'd1);
    check("bp_after_vld", 32'(b2.rsp_valid), 32'd0);
    b2.req_valid[0] = 1'b0;
    @(posedge clk); #1;

    // Fairness: pointer sits at 1 after the last grant.
    set2(0, 32'd1, 32'd1, ALU_ADD);
    set2(1, 32'd2, 32'd2, ALU_ADD);
    for (int n = 0; n < 4; n++) begin
`ifdef SR_ALU_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 2;
`endif
      exp_r = (exp_id == 0) ? 32'd2 : 32'd4;
      xact2(exp_id, 1'b1, 0, exp_r, 1'b0);
    end
    b2.req_valid = '0;

    // Reset while the request is in EXEC.
    set2(0, 32'h1234, 32'h1, ALU_ADD);
    @(negedge clk);
    check("mr_grant", 32'(b2.req_ready), 32'd1);
    @(posedge clk); #1;
    b2.req_valid[0] = 1'b0;
    @(negedge clk);
    check("mr_exec_srcA", a2_a, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("mr_srcA", a2_a, 32'd0);
    check("mr_valid", 32'(b2.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b2.rsp_valid) seen = 1'b1;
    end
    check("mr_no_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;
    set2(0, 32'hF0F0_0000, 32'h0F0F_0000, ALU_XOR);
    xact2(0, 1'b0, 0, 32'hFFFF_0000, 1'b0);

    // N_REQ=4: pointer 3 after reset, requesters 1 and 3 valid.
    set4(1, 32'h0F00, 32'h00F0, ALU_OR);
    set4(3, 32'd3, 32'd4, ALU_SLTU);
    xact4(1, 32'h0FF0, ALU_OR);
    xact4(3, 32'd1, ALU_SLTU);
    set4(2, 32'h80, 32'd4, ALU_SRL);
    xact4(2, 32'h8, ALU_SRL);
    set4(0, 32'd2, 32'd3, 3'b111);
    xact4(0, 32'd5, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
